// File: rtl/hit_monitor.sv
// Ghost/Pacman catch detector and lives/freeze game FSM.
// Catches are detected only on tick; a catch freezes the movers for FREEZE_TICKS ticks, then respawn pulses.
module hit_monitor #(
    parameter int HIT_DIST     = 12,
    parameter int LIVES        = 3,
    parameter int FREEZE_TICKS = 60
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick,
    input  logic       start,
    input  logic [9:0] pac_x,
    input  logic [8:0] pac_y,
    input  logic [9:0] ghost_x,
    input  logic [8:0] ghost_y,
    output logic       hit,
    output logic       respawn,
    output logic       freeze,
    output logic [1:0] lives,
    output logic       game_over,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PLAY = 2'b01,
        FRZ  = 2'b10,
        OVER = 2'b11
    } state_t;

    state_t      st, st_nx;
    logic [1:0]  lives_nx;
    logic [7:0]  cnt, cnt_nx;
    logic        hit_nx, resp_nx;
    logic [10:0] dx;
    logic [9:0]  dy;
    logic        overlap;

    // One extra bit so the subtraction never wraps before the compare.
    always_comb begin
        dx = (pac_x >= ghost_x) ? ({1'b0, pac_x} - {1'b0, ghost_x})
                                : ({1'b0, ghost_x} - {1'b0, pac_x});
        dy = (pac_y >= ghost_y) ? ({1'b0, pac_y} - {1'b0, ghost_y})
                                : ({1'b0, ghost_y} - {1'b0, pac_y});
        overlap = (dx < 11'(HIT_DIST)) && (dy < 10'(HIT_DIST));
    end

    always_comb begin
        st_nx    = st;
        lives_nx = lives;
        cnt_nx   = cnt;
        hit_nx   = 1'b0;
        resp_nx  = 1'b0;
        case (st)
            IDLE, OVER: begin
                if (start) begin
                    lives_nx = 2'(LIVES);
                    st_nx    = PLAY;
                end
            end
            PLAY: begin
                if (tick && overlap) begin
                    hit_nx = 1'b1;
                    if (lives > 2'd1) begin
                        lives_nx = lives - 2'd1;
                        cnt_nx   = 8'(FREEZE_TICKS);
                        st_nx    = FRZ;
                    end else begin
                        lives_nx = 2'd0;
                        st_nx    = OVER;
                    end
                end
            end
            FRZ: begin
                if (tick) begin
                    if (cnt <= 8'd1) begin
                        cnt_nx  = 8'd0;
                        resp_nx = 1'b1;
                        st_nx   = PLAY;
                    end else begin
                        cnt_nx = cnt - 8'd1;
                    end
                end
            end
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            st      <= IDLE;
            lives   <= 2'd0;
            cnt     <= 8'd0;
            hit     <= 1'b0;
            respawn <= 1'b0;
        end else begin
            st      <= st_nx;
            lives   <= lives_nx;
            cnt     <= cnt_nx;
            hit     <= hit_nx;
            respawn <= resp_nx;
        end
    end

    // OVER also holds the movers, hence freeze on the state MSB.
    assign freeze    = st[1];
    assign game_over = (st == OVER);
    assign state     = st;

endmodule

// File: tb/tb_hit_monitor.sv
// Directed bench for hit_monitor: reset, thresholds, freeze timing, game over, async reset.
module tb_hit_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tick = 1'b0;
    logic       start = 1'b0;
    logic [9:0] pac_x = '0, ghost_x = '0;
    logic [8:0] pac_y = '0, ghost_y = '0;
    logic       hit, respawn, freeze, game_over;
    logic [1:0] lives, state;

    int errors = 0;
    int checks = 0;

    hit_monitor #(.HIT_DIST(12), .LIVES(3), .FREEZE_TICKS(60)) dut (
        .clk(clk), .rst(rst), .tick(tick), .start(start),
        .pac_x(pac_x), .pac_y(pac_y), .ghost_x(ghost_x), .ghost_y(ghost_y),
        .hit(hit), .respawn(respawn), .freeze(freeze), .lives(lives),
        .game_over(game_over), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive tick for one cycle, then sample just after the edge.
    task automatic step(input logic t);
        @(negedge clk);
        tick = t;
        @(posedge clk);
        #1;
    endtask

    task automatic pos(input int px, input int py, input int gx, input int gy);
        pac_x = 10'(px); pac_y = 9'(py); ghost_x = 10'(gx); ghost_y = 9'(gy);
    endtask

    // Count out a full freeze, expecting respawn only after the last tick.
    task automatic run_freeze(input string tag);
        int bad = 0;
        for (int i = 1; i < 60; i++) begin
            step(1'b1);
            if (hit !== 1'b0 || respawn !== 1'b0 || state !== 2'b10) bad++;
            if (i == 30) begin
                start = 1'b1;
                for (int j = 0; j < 4; j++) begin
                    step(1'b0);
                    if (state !== 2'b10 || respawn !== 1'b0) bad++;
                end
                start = 1'b0;
            end
        end
        chk({tag, "_hold"}, bad, 0);
        step(1'b1);
        chk({tag, "_respawn"}, respawn, 1);
        chk({tag, "_state_play"}, state, 2'b01);
        chk({tag, "_nofreeze"}, freeze, 0);
        step(1'b0);
        chk({tag, "_respawn_1cyc"}, respawn, 0);
    endtask

    initial begin
        // Reset state
        #2;
        chk("rst_state", state, 0);
        chk("rst_lives", lives, 0);
        chk("rst_outs", {hit, respawn, freeze, game_over}, 0);
        step(1'b0);
        rst = 1'b1;

        // Overlap ignored in IDLE; stays IDLE without start
        pos(100, 100, 100, 100);
        step(1'b1);
        step(1'b1);
        chk("idle_nohit", hit, 0);
        chk("idle_stay", state, 2'b00);

        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        chk("start_play", state, 2'b01);
        chk("start_lives", lives, 3);

        // Distance equal to HIT_DIST on either axis is not an overlap
        pos(100, 100, 112, 100);
        step(1'b1);
        chk("dx12_nohit", hit, 0);
        pos(100, 100, 100, 112);
        step(1'b1);
        chk("dy12_nohit", hit, 0);
        // No 10-bit wrap: |1020-5| is large, not 9
        pos(1020, 5, 5, 5);
        step(1'b1);
        chk("nowrap_nohit", hit, 0);
        // Overlap without tick is ignored
        pos(100, 100, 111, 100);
        step(1'b0);
        chk("notick_nohit", hit, 0);

        // First catch
        step(1'b1);
        chk("hit1", hit, 1);
        chk("hit1_lives", lives, 2);
        chk("hit1_state", state, 2'b10);
        chk("hit1_freeze", freeze, 1);
        step(1'b0);
        chk("hit1_1cyc", hit, 0);
        run_freeze("frz1");

        // Second catch
        step(1'b1);
        chk("hit2_lives", lives, 1);
        chk("hit2_state", state, 2'b10);
        run_freeze("frz2");

        // Third catch -> OVER
        step(1'b1);
        chk("hit3", hit, 1);
        chk("hit3_lives", lives, 0);
        chk("over_state", state, 2'b11);
        chk("over_flags", {game_over, freeze}, 2'b11);
        step(1'b1);
        chk("over_nohit", hit, 0);
        chk("over_lives0", lives, 0);
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        chk("restart_lives", lives, 3);
        chk("restart_state", state, 2'b01);

        // abs difference, pac greater than ghost
        pos(5, 5, 0, 0);
        step(1'b1);
        chk("abs_pac_gt", hit, 1);
        chk("abs_pac_gt_state", state, 2'b10);
        step(1'b1);

        // Async reset mid-freeze, between edges
        #2;
        rst = 1'b0;
        #1;
        chk("arst_state", state, 0);
        chk("arst_lives", lives, 0);
        chk("arst_outs", {hit, respawn, freeze, game_over}, 0);
        step(1'b1);
        rst = 1'b1;
        begin
            int bad = 0;
            for (int i = 0; i < 70; i++) begin
                step(1'b1);
                if (respawn !== 1'b0 || state !== 2'b00) bad++;
            end
            chk("arst_norespawn", bad, 0);
        end

        // abs difference, ghost greater than pac
        start = 1'b1;
        step(1'b0);
        start = 1'b0;
        pos(0, 0, 5, 5);
        step(1'b1);
        chk("abs_ghost_gt", hit, 1);
        chk("abs_ghost_gt_lives", lives, 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
